// File: rtl/matrix_loader.sv
// ============================================================================
// Module   : matrix_loader
// Purpose  : Write-side sequencer that streams 16-bit words into an 8x8
//            matrix RAM in row-major order and pulses done when complete.
//            Optional macro TRANSPOSE_EN adds a transpose input that stores
//            the stream column-major instead.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int DIM        = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
`ifdef TRANSPOSE_EN
  input  logic                  transpose,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  Wen,
  output logic [ADDR_WIDTH-1:0] Wi_address,
  output logic [ADDR_WIDTH-1:0] Wj_address,
  output logic [DATA_WIDTH-1:0] W_data,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_LAST = ADDR_WIDTH'(DIM - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   i_q, i_d;
  logic [ADDR_WIDTH-1:0]   j_q, j_d;
  logic                    wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]   wi_q, wi_d;
  logic [ADDR_WIDTH-1:0]   wj_q, wj_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    done_q, done_d;
  logic                    tr_q, tr_d;
  logic                    w_accept;

  assign w_accept = in_valid && (state_q == ST_LOAD);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    wen_d   = 1'b0;
    wi_d    = wi_q;
    wj_d    = wj_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    tr_d    = tr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
`ifdef TRANSPOSE_EN
          tr_d    = transpose;
`else
          tr_d    = 1'b0;
`endif
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // abort wins over a simultaneous accept: nothing is registered
        if (abort) begin
          state_d = ST_IDLE;
        end else if (w_accept) begin
          wen_d   = 1'b1;
          wdata_d = in_data;
          wi_d    = tr_q ? j_q : i_q;
          wj_d    = tr_q ? i_q : j_q;
          j_d     = j_q + 1'b1;
          if (j_q == C_LAST) begin
            i_d = i_q + 1'b1;
            if (i_q == C_LAST) begin
              state_d = ST_FLUSH;
            end
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        done_d  = !abort;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      wen_q   <= 1'b0;
      wi_q    <= '0;
      wj_q    <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      tr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      wen_q   <= wen_d;
      wi_q    <= wi_d;
      wj_q    <= wj_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      tr_q    <= tr_d;
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_IDLE);
  assign Wen        = wen_q;
  assign Wi_address = wi_q;
  assign Wj_address = wj_q;
  assign W_data     = wdata_q;
  assign done       = done_q;

endmodule

`default_nettype wire
